dx_stage_reg: RTL and testbench
===============================

DX_STAGE_REG -- requirements
Module: dx_stage_reg

Interface
REQ-001 SHALL have parameter DATA_W, default 32, operand and PC width.
REQ-002 SHALL have parameter REG_ADDR_W, default 5, register-index width.
REQ-003 SHALL have parameter INSN_W, default 32, instruction width.
REQ-004 SHALL have port clock  in  1  the single clock; all state updates on its rising edge.
REQ-005 SHALL have port ctrl_reset_n  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have ports ctrl_stall  in  1  hold all stage contents; ctrl_flush  in  1  insert a bubble.
REQ-007 SHALL have ports fd_valid  in  1; fd_insn  in  INSN_W; fd_pc  in  DATA_W: the decode-stage instruction.
REQ-008 SHALL have ports fd_rs_a, fd_rs_b  in  REG_ADDR_W: source indices, also driven to the register file read ports.
REQ-009 SHALL have ports rf_data_a, rf_data_b  in  DATA_W: register file read data for fd_rs_a and fd_rs_b.
REQ-010 SHALL have ports wb_we  in  1; wb_rd  in  REG_ADDR_W; wb_data  in  DATA_W: the same write request presented to the register file this cycle.
REQ-011 SHALL have outputs dx_valid 1, dx_insn INSN_W, dx_pc DATA_W, dx_op_a DATA_W, dx_op_b DATA_W, dx_rs_a REG_ADDR_W, dx_rs_b REG_ADDR_W: the registered execute-stage bundle.

Function
REQ-012 SHALL register every dx_* output, with latency exactly one clock from fd_*/rf_* to dx_*.
REQ-013 SHALL apply per-edge priority reset > flush > stall > load.
REQ-014 Load (no stall, no flush) SHALL capture dx_valid=fd_valid, dx_insn=fd_insn, dx_pc=fd_pc, dx_rs_*=fd_rs_*, and dx_op_*=selected operand (REQ-016).
REQ-015 Flush SHALL set dx_valid=0, dx_insn=NOP (all zero), dx_rs_a=dx_rs_b=0, dx_op_a=dx_op_b=0, dx_pc=0, regardless of ctrl_stall.
REQ-016 Operand select at load: if the feature is enabled, wb_we=1, wb_rd==fd_rs_x and wb_rd!=0, use wb_data; otherwise use rf_data_x.
REQ-017 Stall SHALL hold dx_valid, dx_insn, dx_pc and dx_rs_* unchanged.
REQ-018 During stall, if the feature is enabled, wb_we=1, wb_rd==dx_rs_x and wb_rd!=0, dx_op_x SHALL update to wb_data; otherwise dx_op_x holds.
REQ-019 Index 0 SHALL never be bypassed; dx_op_x SHALL be 0 whenever captured with fd_rs_x==0, independent of rf_data_x.
REQ-020 A write matching both sources SHALL update both operands in the same edge.
REQ-021 Operand capture and refresh SHALL be independent of fd_valid and dx_valid; bubbles carry operand values that downstream logic ignores.

Reset
REQ-022 Assertion of ctrl_reset_n low SHALL immediately clear all dx_* outputs to 0, with dx_insn equal to NOP.
REQ-023 Reset asserted mid-stall SHALL discard held contents; the first edge after deassertion SHALL perform a normal load, flush or stall per REQ-013.

Configuration
REQ-024 Macro DX_WB_BYPASS_EN SHALL control writeback forwarding.
- Defined: REQ-016 and REQ-018 forwarding is active.
- Undefined: dx_op_x = rf_data_x at load and holds during stall; no comparators are synthesized, and downstream forwarding must cover the gap.

Structure
REQ-025 A shared package SHALL hold DATA_W, REG_ADDR_W and INSN_W defaults, the NOP constant, and the zero-register index constant.
REQ-026 Sub-module dx_operand_bypass SHALL implement one operand's compare/select for both the load and stall paths, instantiated twice (A, B) and compiled under DX_WB_BYPASS_EN.

Verification
REQ-027 Load: fd_valid=1, fd_pc=0x40, fd_rs_a=3, rf_data_a=0x11, wb_we=0 -> next edge dx_valid=1, dx_pc=0x40, dx_op_a=0x11.
REQ-028 Same-cycle bypass: fd_rs_a=5, rf_data_a=0x0, wb_we=1, wb_rd=5, wb_data=0xDEAD -> dx_op_a=0xDEAD (macro on) or 0x0 (macro off).
REQ-029 Zero register: fd_rs_b=0, wb_we=1, wb_rd=0, wb_data=0xFFFF -> dx_op_b=0.
REQ-030 Stall refresh: capture dx_rs_a=dx_rs_b=7, op=0x1, then stall 3 cycles with wb_rd=7, wb_data=0x99 in the second stall cycle -> dx_op_a=dx_op_b=0x99 (macro on), dx_insn/dx_pc unchanged, 0x1 if macro off.
REQ-031 Flush during stall: ctrl_stall=1, ctrl_flush=1 -> dx_valid=0, dx_insn=0; the following unstalled edge loads normally.
REQ-032 Async reset: drive ctrl_reset_n low between edges while dx_valid=1 -> all outputs 0 before the next edge; first edge after release loads fd_*.

Source files
------------

// File: rtl/dx_stage_reg_pkg.sv
// rtl/dx_stage_reg_pkg.sv - shared widths and constants for the decode/execute stage register
//
// Purpose : default widths, the NOP encoding and the hard-wired zero register index
//           shared by dx_stage_reg, its interface and dx_operand_bypass.
// Ports   : none (package).
package dx_stage_reg_pkg;

   localparam int DX_DATA_W     = 32;
   localparam int DX_REG_ADDR_W = 5;
   localparam int DX_INSN_W     = 32;

   // A bubble carries an all-zero instruction word.
   localparam logic [DX_INSN_W-1:0] DX_NOP = '0;

   // Register index 0 reads as zero and is never a forwarding target.
   localparam int unsigned DX_ZERO_REG = 0;

endpackage

// File: rtl/dx_stage_reg_if.sv
// rtl/dx_stage_reg_if.sv - decode/execute stage bundle interface
//
// Purpose : groups the pipeline control, decode-side inputs, register file read data,
//           writeback request and the registered execute-side bundle.
// Modports: master - drives ctrl/fd/rf/wb, observes dx (pipeline environment)
//           slave  - consumes ctrl/fd/rf/wb, drives dx (dx_stage_reg)
interface dx_stage_reg_if #(
   parameter int DATA_W     = dx_stage_reg_pkg::DX_DATA_W,
   parameter int REG_ADDR_W = dx_stage_reg_pkg::DX_REG_ADDR_W,
   parameter int INSN_W     = dx_stage_reg_pkg::DX_INSN_W
) ();

   logic                  ctrl_stall;
   logic                  ctrl_flush;

   logic                  fd_valid;
   logic [INSN_W-1:0]     fd_insn;
   logic [DATA_W-1:0]     fd_pc;
   logic [REG_ADDR_W-1:0] fd_rs_a;
   logic [REG_ADDR_W-1:0] fd_rs_b;

   logic [DATA_W-1:0]     rf_data_a;
   logic [DATA_W-1:0]     rf_data_b;

   logic                  wb_we;
   logic [REG_ADDR_W-1:0] wb_rd;
   logic [DATA_W-1:0]     wb_data;

   logic                  dx_valid;
   logic [INSN_W-1:0]     dx_insn;
   logic [DATA_W-1:0]     dx_pc;
   logic [DATA_W-1:0]     dx_op_a;
   logic [DATA_W-1:0]     dx_op_b;
   logic [REG_ADDR_W-1:0] dx_rs_a;
   logic [REG_ADDR_W-1:0] dx_rs_b;

   modport master (
      output ctrl_stall, ctrl_flush,
      output fd_valid, fd_insn, fd_pc, fd_rs_a, fd_rs_b,
      output rf_data_a, rf_data_b,
      output wb_we, wb_rd, wb_data,
      input  dx_valid, dx_insn, dx_pc, dx_op_a, dx_op_b, dx_rs_a, dx_rs_b
   );

   modport slave (
      input  ctrl_stall, ctrl_flush,
      input  fd_valid, fd_insn, fd_pc, fd_rs_a, fd_rs_b,
      input  rf_data_a, rf_data_b,
      input  wb_we, wb_rd, wb_data,
      output dx_valid, dx_insn, dx_pc, dx_op_a, dx_op_b, dx_rs_a, dx_rs_b
   );

endinterface

// File: rtl/dx_operand_bypass.sv
// rtl/dx_operand_bypass.sv - one operand's writeback compare/select (load and stall paths)
//
// Purpose : picks the value an operand register takes on a load edge and on a stall edge,
//           forwarding the concurrent writeback when it targets the operand's register.
//           Only compiled when DX_WB_BYPASS_EN is defined.
// Ports   : fd_rs/rf_data   - source index and register file data at decode
//           dx_rs/dx_op     - index and value currently held in the stage
//           wb_we/wb_rd/wb_data - writeback request of this cycle
//           load_op         - operand to capture on a load edge
//           stall_op        - operand to keep on a stall edge
`ifdef DX_WB_BYPASS_EN
module dx_operand_bypass
   import dx_stage_reg_pkg::*;
#(
   parameter int DATA_W     = DX_DATA_W,
   parameter int REG_ADDR_W = DX_REG_ADDR_W
) (
   input  logic [REG_ADDR_W-1:0] fd_rs,
   input  logic [DATA_W-1:0]     rf_data,
   input  logic [REG_ADDR_W-1:0] dx_rs,
   input  logic [DATA_W-1:0]     dx_op,
   input  logic                  wb_we,
   input  logic [REG_ADDR_W-1:0] wb_rd,
   input  logic [DATA_W-1:0]     wb_data,
   output logic [DATA_W-1:0]     load_op,
   output logic [DATA_W-1:0]     stall_op
);

   localparam logic [REG_ADDR_W-1:0] ZERO_REG = REG_ADDR_W'(DX_ZERO_REG);

   // A write to the zero register is architecturally discarded, so it never forwards.
   logic wb_live;
   assign wb_live = wb_we && (wb_rd != ZERO_REG);

   always_comb begin
      load_op = rf_data;
      if (fd_rs == ZERO_REG) begin
         load_op = '0;
      end else if (wb_live && (wb_rd == fd_rs)) begin
         load_op = wb_data;
      end
   end

   // While stalled the held operand would otherwise miss a write that retires meanwhile.
   assign stall_op = (wb_live && (wb_rd == dx_rs)) ? wb_data : dx_op;

endmodule
`endif

// File: rtl/dx_stage_reg.sv
// rtl/dx_stage_reg.sv - decode-to-execute pipeline stage register with optional writeback forwarding
//
// Purpose : registers the decode bundle into the execute stage with one clock of latency.
//           Edge priority: reset > flush > stall > load. Define DX_WB_BYPASS_EN to forward
//           the concurrent writeback into the operands on load and stall edges.
// Ports   : clock        - rising-edge clock
//           ctrl_reset_n - asynchronous active-low reset
//           bus          - dx_stage_reg_if.slave: ctrl_stall/ctrl_flush, fd_*, rf_*, wb_* in; dx_* out
module dx_stage_reg
   import dx_stage_reg_pkg::*;
#(
   parameter int DATA_W     = DX_DATA_W,
   parameter int REG_ADDR_W = DX_REG_ADDR_W,
   parameter int INSN_W     = DX_INSN_W
) (
   input  logic          clock,
   input  logic          ctrl_reset_n,
   dx_stage_reg_if.slave bus
);

   localparam logic [INSN_W-1:0]     NOP_INSN = INSN_W'(DX_NOP);
   localparam logic [REG_ADDR_W-1:0] ZERO_REG = REG_ADDR_W'(DX_ZERO_REG);

   logic                  dx_valid_q, dx_valid_d;
   logic [INSN_W-1:0]     dx_insn_q,  dx_insn_d;
   logic [DATA_W-1:0]     dx_pc_q,    dx_pc_d;
   logic [DATA_W-1:0]     dx_op_a_q,  dx_op_a_d;
   logic [DATA_W-1:0]     dx_op_b_q,  dx_op_b_d;
   logic [REG_ADDR_W-1:0] dx_rs_a_q,  dx_rs_a_d;
   logic [REG_ADDR_W-1:0] dx_rs_b_q,  dx_rs_b_d;

   logic [DATA_W-1:0]     load_op_a, load_op_b;
   logic [DATA_W-1:0]     stall_op_a, stall_op_b;

`ifdef DX_WB_BYPASS_EN
   dx_operand_bypass #(.DATA_W(DATA_W), .REG_ADDR_W(REG_ADDR_W)) u_bypass_a (
      .fd_rs   (bus.fd_rs_a),
      .rf_data (bus.rf_data_a),
      .dx_rs   (dx_rs_a_q),
      .dx_op   (dx_op_a_q),
      .wb_we   (bus.wb_we),
      .wb_rd   (bus.wb_rd),
      .wb_data (bus.wb_data),
      .load_op (load_op_a),
      .stall_op(stall_op_a)
   );

   dx_operand_bypass #(.DATA_W(DATA_W), .REG_ADDR_W(REG_ADDR_W)) u_bypass_b (
      .fd_rs   (bus.fd_rs_b),
      .rf_data (bus.rf_data_b),
      .dx_rs   (dx_rs_b_q),
      .dx_op   (dx_op_b_q),
      .wb_we   (bus.wb_we),
      .wb_rd   (bus.wb_rd),
      .wb_data (bus.wb_data),
      .load_op (load_op_b),
      .stall_op(stall_op_b)
   );
`else
   // Without forwarding the writeback request is not looked at; a later stage covers the gap.
   assign load_op_a  = (bus.fd_rs_a == ZERO_REG) ? '0 : bus.rf_data_a;
   assign load_op_b  = (bus.fd_rs_b == ZERO_REG) ? '0 : bus.rf_data_b;
   assign stall_op_a = dx_op_a_q;
   assign stall_op_b = dx_op_b_q;

   logic unused_wb;
   assign unused_wb = ^{bus.wb_we, bus.wb_rd, bus.wb_data};
`endif

   always_comb begin
      dx_valid_d = dx_valid_q;
      dx_insn_d  = dx_insn_q;
      dx_pc_d    = dx_pc_q;
      dx_op_a_d  = dx_op_a_q;
      dx_op_b_d  = dx_op_b_q;
      dx_rs_a_d  = dx_rs_a_q;
      dx_rs_b_d  = dx_rs_b_q;

      if (bus.ctrl_flush) begin
         // Flush wins over stall: the bubble is fully cleared, not just invalidated.
         dx_valid_d = 1'b0;
         dx_insn_d  = NOP_INSN;
         dx_pc_d    = '0;
         dx_op_a_d  = '0;
         dx_op_b_d  = '0;
         dx_rs_a_d  = ZERO_REG;
         dx_rs_b_d  = ZERO_REG;
      end else if (bus.ctrl_stall) begin
         dx_op_a_d  = stall_op_a;
         dx_op_b_d  = stall_op_b;
      end else begin
         dx_valid_d = bus.fd_valid;
         dx_insn_d  = bus.fd_insn;
         dx_pc_d    = bus.fd_pc;
         dx_op_a_d  = load_op_a;
         dx_op_b_d  = load_op_b;
         dx_rs_a_d  = bus.fd_rs_a;
         dx_rs_b_d  = bus.fd_rs_b;
      end
   end

   always_ff @(posedge clock or negedge ctrl_reset_n) begin
      if (!ctrl_reset_n) begin
         dx_valid_q <= 1'b0;
         dx_insn_q  <= NOP_INSN;
         dx_pc_q    <= '0;
         dx_op_a_q  <= '0;
         dx_op_b_q  <= '0;
         dx_rs_a_q  <= ZERO_REG;
         dx_rs_b_q  <= ZERO_REG;
      end else begin
         dx_valid_q <= dx_valid_d;
         dx_insn_q  <= dx_insn_d;
         dx_pc_q    <= dx_pc_d;
         dx_op_a_q  <= dx_op_a_d;
         dx_op_b_q  <= dx_op_b_d;
         dx_rs_a_q  <= dx_rs_a_d;
         dx_rs_b_q  <= dx_rs_b_d;
      end
   end

   assign bus.dx_valid = dx_valid_q;
   assign bus.dx_insn  = dx_insn_q;
   assign bus.dx_pc    = dx_pc_q;
   assign bus.dx_op_a  = dx_op_a_q;
   assign bus.dx_op_b  = dx_op_b_q;
   assign bus.dx_rs_a  = dx_rs_a_q;
   assign bus.dx_rs_b  = dx_rs_b_q;

endmodule

// File: tb/tb_dx_stage_reg.sv
// tb/tb_dx_stage_reg.sv - self-checking bench for dx_stage_reg (either DX_WB_BYPASS_EN setting)
module tb_dx_stage_reg;

`ifdef DX_WB_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic clock;
   logic ctrl_reset_n;
   int   total;
   int   bad;
   bit   chk_en;

   // Expected execute-stage contents.
   logic        e_valid;
   logic [31:0] e_insn, e_pc, e_op_a, e_op_b;
   logic [4:0]  e_rs_a, e_rs_b;

   dx_stage_reg_if bus ();

   dx_stage_reg dut (
      .clock       (clock),
      .ctrl_reset_n(ctrl_reset_n),
      .bus         (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Value an instruction reading register rs at decode must see.
   function automatic logic [31:0] read_val(input logic [4:0] rs, input logic [31:0] rf);
      if (rs == 5'd0) return 32'd0;
      if (BYP && bus.wb_we && bus.wb_rd == rs) return bus.wb_data;
      return rf;
   endfunction

   // Value a held operand must have after an edge on which register rs may be written.
   function automatic logic [31:0] held_val(input logic [4:0] rs, input logic [31:0] cur);
      if (BYP && bus.wb_we && bus.wb_rd != 5'd0 && bus.wb_rd == rs) return bus.wb_data;
      return cur;
   endfunction

   task automatic clear_exp();
      e_valid = 1'b0; e_insn = '0; e_pc = '0; e_op_a = '0; e_op_b = '0; e_rs_a = '0; e_rs_b = '0;
   endtask

   // Advance one edge; the model takes its next state from the inputs presented now.
   task automatic tick();
      logic        n_valid;
      logic [31:0] n_insn, n_pc, n_op_a, n_op_b;
      logic [4:0]  n_rs_a, n_rs_b;
      n_valid = e_valid; n_insn = e_insn; n_pc = e_pc;
      n_op_a = e_op_a; n_op_b = e_op_b; n_rs_a = e_rs_a; n_rs_b = e_rs_b;
      if (!ctrl_reset_n || bus.ctrl_flush) begin
         n_valid = 1'b0; n_insn = '0; n_pc = '0; n_op_a = '0; n_op_b = '0; n_rs_a = '0; n_rs_b = '0;
      end else if (bus.ctrl_stall) begin
         n_op_a = held_val(e_rs_a, e_op_a);
         n_op_b = held_val(e_rs_b, e_op_b);
      end else begin
         n_valid = bus.fd_valid; n_insn = bus.fd_insn; n_pc = bus.fd_pc;
         n_rs_a = bus.fd_rs_a; n_rs_b = bus.fd_rs_b;
         n_op_a = read_val(bus.fd_rs_a, bus.rf_data_a);
         n_op_b = read_val(bus.fd_rs_b, bus.rf_data_b);
      end
      @(posedge clock);
      #1;
      e_valid = n_valid; e_insn = n_insn; e_pc = n_pc;
      e_op_a = n_op_a; e_op_b = n_op_b; e_rs_a = n_rs_a; e_rs_b = n_rs_b;
   endtask

   task automatic set_fd(input logic v, input logic [31:0] insn, input logic [31:0] pc,
                         input logic [4:0] ra, input logic [31:0] da,
                         input logic [4:0] rb, input logic [31:0] db);
      bus.fd_valid = v; bus.fd_insn = insn; bus.fd_pc = pc;
      bus.fd_rs_a = ra; bus.rf_data_a = da; bus.fd_rs_b = rb; bus.rf_data_b = db;
   endtask

   task automatic set_wb(input logic we, input logic [4:0] rd, input logic [31:0] data);
      bus.wb_we = we; bus.wb_rd = rd; bus.wb_data = data;
   endtask

   // Model comparison on every falling edge once the bench has started.
   always @(negedge clock) begin
      if (chk_en) begin
         chk("cyc_valid", bus.dx_valid, e_valid);
         chk("cyc_insn",  bus.dx_insn,  e_insn);
         chk("cyc_pc",    bus.dx_pc,    e_pc);
         chk("cyc_op_a",  bus.dx_op_a,  e_op_a);
         chk("cyc_op_b",  bus.dx_op_b,  e_op_b);
         chk("cyc_rs_a",  bus.dx_rs_a,  e_rs_a);
         chk("cyc_rs_b",  bus.dx_rs_b,  e_rs_b);
      end
   end

   initial begin
      total = 0; bad = 0; chk_en = 1'b0;
      ctrl_reset_n = 1'b0;
      bus.ctrl_stall = 1'b0; bus.ctrl_flush = 1'b0;
      set_fd(1'b0, '0, '0, '0, '0, '0, '0);
      set_wb(1'b0, '0, '0);
      clear_exp();
      repeat (2) @(posedge clock);
      #1;
      chk("rst_valid", bus.dx_valid, 0);
      chk("rst_insn",  bus.dx_insn,  0);
      chk("rst_pc",    bus.dx_pc,    0);
      chk("rst_op_a",  bus.dx_op_a,  0);
      chk("rst_rs_b",  bus.dx_rs_b,  0);
      ctrl_reset_n = 1'b1;
      chk_en = 1'b1;

      // Plain load.
      set_fd(1'b1, 32'h13, 32'h40, 5'd3, 32'h11, 5'd4, 32'h22);
      tick();
      chk("load_valid", bus.dx_valid, 1);
      chk("load_pc",    bus.dx_pc,    32'h40);
      chk("load_op_a",  bus.dx_op_a,  32'h11);
      chk("load_op_b",  bus.dx_op_b,  32'h22);
      chk("load_rs_a",  bus.dx_rs_a,  3);

      // Same-cycle writeback to source A.
      set_fd(1'b1, 32'h23, 32'h44, 5'd5, 32'h0, 5'd6, 32'h66);
      set_wb(1'b1, 5'd5, 32'hDEAD);
      tick();
      chk("byp_op_a", bus.dx_op_a, BYP ? 32'hDEAD : 32'h0);
      chk("byp_op_b", bus.dx_op_b, 32'h66);

      // Zero register never forwards and ignores the register file.
      set_fd(1'b1, 32'h33, 32'h48, 5'd0, 32'h1234, 5'd0, 32'h5678);
      set_wb(1'b1, 5'd0, 32'hFFFF);
      tick();
      chk("zero_op_a", bus.dx_op_a, 0);
      chk("zero_op_b", bus.dx_op_b, 0);

      // Stall refresh: both sources are r7, write lands in the second stall cycle.
      set_fd(1'b1, 32'hABC, 32'h80, 5'd7, 32'h1, 5'd7, 32'h1);
      set_wb(1'b0, 5'd0, 32'h0);
      tick();
      chk("stl_cap_op_a", bus.dx_op_a, 1);
      bus.ctrl_stall = 1'b1;
      set_fd(1'b1, 32'hBAD, 32'hF0, 5'd2, 32'h77, 5'd9, 32'h88);
      tick();
      set_wb(1'b1, 5'd7, 32'h99);
      tick();
      set_wb(1'b0, 5'd7, 32'h55);
      tick();
      chk("stl_op_a", bus.dx_op_a, BYP ? 32'h99 : 32'h1);
      chk("stl_op_b", bus.dx_op_b, BYP ? 32'h99 : 32'h1);
      chk("stl_insn", bus.dx_insn, 32'hABC);
      chk("stl_pc",   bus.dx_pc,   32'h80);
      chk("stl_rs_a", bus.dx_rs_a, 7);

      // Flush while stalled, then a normal load.
      bus.ctrl_flush = 1'b1;
      tick();
      chk("fl_valid", bus.dx_valid, 0);
      chk("fl_insn",  bus.dx_insn,  0);
      chk("fl_op_a",  bus.dx_op_a,  0);
      bus.ctrl_flush = 1'b0; bus.ctrl_stall = 1'b0;
      set_fd(1'b1, 32'h43, 32'hC0, 5'd1, 32'hA1, 5'd2, 32'hB2);
      tick();
      chk("fl_next_valid", bus.dx_valid, 1);
      chk("fl_next_pc",    bus.dx_pc,    32'hC0);
      chk("fl_next_op_b",  bus.dx_op_b,  32'hB2);

      // Asynchronous reset between edges while valid.
      #1;
      ctrl_reset_n = 1'b0;
      clear_exp();
      #1;
      chk("arst_valid", bus.dx_valid, 0);
      chk("arst_pc",    bus.dx_pc,    0);
      chk("arst_op_a",  bus.dx_op_a,  0);
      #3;
      ctrl_reset_n = 1'b1;
      set_fd(1'b1, 32'h53, 32'h100, 5'd8, 32'hC3, 5'd9, 32'hD4);
      tick();
      chk("arst_load_valid", bus.dx_valid, 1);
      chk("arst_load_pc",    bus.dx_pc,    32'h100);

      // Reset asserted mid-stall: held contents are gone, the next stall holds zeros.
      bus.ctrl_stall = 1'b1;
      #2;
      ctrl_reset_n = 1'b0;
      clear_exp();
      #2;
      ctrl_reset_n = 1'b1;
      tick();
      chk("rst_stl_pc", bus.dx_pc, 0);
      bus.ctrl_stall = 1'b0;
      tick();
      chk("rst_stl_load_pc", bus.dx_pc, 32'h100);

      // Mixed cycles checked by the model only.
      for (int i = 0; i < 40; i++) begin
         bus.ctrl_stall = ($urandom_range(0, 2) == 0);
         bus.ctrl_flush = ($urandom_range(0, 7) == 0);
         set_fd(1'($urandom_range(0, 1)), $urandom, $urandom,
                5'($urandom_range(0, 7)), $urandom, 5'($urandom_range(0, 7)), $urandom);
         set_wb(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom);
         tick();
      end

      @(negedge clock);
      #1;
      chk_en = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
